// File: rtl/iram_1r1w1ck_clr.sv
// Simple dual-port RAM with per-lane write mask, selectable read-during-write and a post-reset clear sequencer.
// Optional macro IRAM_OUTREG_EN adds a second output register stage (read latency 2).
module iram_1r1w1ck_clr #(
  parameter int               WIDTH    = 112,
  parameter int               DEPTH    = 64,
  parameter int               LANE_W   = 8,
  parameter int               RDW_NEW  = 0,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int              NL       = WIDTH / LANE_W,
  localparam int              AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic [NL-1:0]    wea,
  input  logic [AW-1:0]    addra,
  input  logic [WIDTH-1:0] dia,
  input  logic             enb,
  input  logic [AW-1:0]    addrb,
  output logic [WIDTH-1:0] dob,
  output logic             dob_vld,
  output logic             init_busy
);

  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [NL-1:0]    wr_mask;
  logic             rd_en;
  logic             rd_vld;
  logic [WIDTH-1:0] ram_q;
  logic [WIDTH-1:0] merged;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      cnt       <= '0;
      init_busy <= 1'b1;
    end else if (state == CLEAR) begin
      if (cnt == LAST) begin
        state     <= READY;
        init_busy <= 1'b0;
      end else begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  // The clear sequencer owns the single write port while busy; user writes are dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addra;
    wr_data = dia;
    wr_mask = wea;
    if (init_busy) begin
      wr_en   = !reset;
      wr_addr = cnt;
      wr_data = INIT_VAL;
      wr_mask = '1;
    end else begin
      wr_en = ena && !reset && ({1'b0, addra} < DEPTH_W);
    end
  end

  assign rd_en = enb && !init_busy && !reset;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NL; i++) begin
        if (wr_mask[i]) mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
      end
    end
  end

  // Read is a separate process so a same-edge read always sees the pre-write word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld <= 1'b0;
      ram_q  <= '0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) ram_q <= mem[addrb];
    end
  end

  generate
    if (RDW_NEW != 0) begin : g_bypass
      logic [WIDTH-1:0] byp_data;
      logic [NL-1:0]    byp_mask;

      always_ff @(posedge clk) begin
        if (reset) begin
          byp_mask <= '0;
        end else if (rd_en) begin
          byp_mask <= (wr_en && (addra == addrb)) ? wea : '0;
          byp_data <= dia;
        end
      end

      for (genvar gi = 0; gi < NL; gi++) begin : g_lane
        assign merged[gi*LANE_W +: LANE_W] = byp_mask[gi] ? byp_data[gi*LANE_W +: LANE_W]
                                                           : ram_q[gi*LANE_W +: LANE_W];
      end
    end else begin : g_no_bypass
      assign merged = ram_q;
    end
  endgenerate

`ifdef IRAM_OUTREG_EN
  logic [WIDTH-1:0] dob_reg;
  logic             vld_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      dob_reg <= '0;
      vld_reg <= 1'b0;
    end else begin
      vld_reg <= rd_vld;
      if (rd_vld) dob_reg <= merged;
    end
  end

  assign dob     = dob_reg;
  assign dob_vld = vld_reg;
`else
  assign dob     = merged;
  assign dob_vld = rd_vld;
`endif

`ifndef SYNTHESIS
  a_wr_range: assert property (@(posedge clk) disable iff (reset || init_busy)
    (ena && |wea) |-> ({1'b0, addra} < DEPTH_W));
  a_rd_range: assert property (@(posedge clk) disable iff (reset || init_busy)
    enb |-> ({1'b0, addrb} < DEPTH_W));
`endif

endmodule

// File: doc/iram_1r1w1ck_clr.md
# iram_1r1w1ck_clr

Parametrised simple dual-port RAM: one write port, one read port, one clock. It is the general successor of the fixed 64x112 buffer RAM. It adds per-lane write masking, selectable read-during-write behaviour, and a hardware clear sequencer, because BRAM contents cannot be reset. Used wherever the ICE datapath needs a deterministic-content BRAM buffer after reset (replay, frame and credit buffers).

## Interface
- `WIDTH`, 112, data width in bits; must be a multiple of `LANE_W`.
- `DEPTH`, 64, number of words; ≥2; need not be a power of two.
- `LANE_W`, 8, bits per write-mask lane; `NL = WIDTH/LANE_W`.
- `RDW_NEW`, 0, same-address read during write: 0 returns old data, 1 returns new (merged) data.
- `INIT_VAL`, 0, `WIDTH`-bit value written to every word by the clear sequence.
- `AW`, derived, `$clog2(DEPTH)`; not to be overridden.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; starts the clear sequence.
- `ena`  in  1  write port enable.
- `wea`  in  NL  per-lane write enable; lane i covers `dia[i*LANE_W +: LANE_W]`.
- `addra`  in  AW  write address.
- `dia`  in  WIDTH  write data.
- `enb`  in  1  read enable.
- `addrb`  in  AW  read address.
- `dob`  out  WIDTH  read data; holds its value between reads.
- `dob_vld`  out  1  one-cycle pulse: `dob` updated by a read.
- `init_busy`  out  1  clear sequence in progress; port accesses are ignored.

## Operation
- **Reset values:** `dob`=0, `dob_vld`=0, `init_busy`=1, clear counter=0. No RAM write happens on a reset edge.
- **Clear FSM, states CLEAR and READY.**
  - Reset forces CLEAR with counter 0.
  - In CLEAR, each edge writes `INIT_VAL` (all lanes) to the counter address and increments the counter.
  - On the edge that writes `DEPTH-1`, the FSM moves to READY and `init_busy` falls.
  - READY is left only by reset.
- **Reset mid-clear:** the clear restarts from address 0. An in-flight `dob_vld` is dropped, and `dob` returns to 0.
- **While `init_busy`=1:** `ena`, `enb` and `wea` are ignored. `dob` holds and `dob_vld`=0.
- **Write (READY):** with `ena`=1, the lanes whose `wea` bit is set take `dia`; the other lanes keep their old contents. `ena`=1 with `wea`=0 is a no-op.
- **Read (READY):** with `enb`=1, `dob` is loaded from `addrb`. With `enb`=0, `dob` holds.
- **Read during write, same address, same edge:**
  - `RDW_NEW`=0: `dob` gets the pre-write word.
  - `RDW_NEW`=1: `dob` gets the written lanes from `dia` and the unwritten lanes from the old word. This is implemented by a registered bypass (captured `dia`/`wea` plus hit flag) merged with the RAM output, and must still infer BRAM.
- **Different addresses:** the read is independent of the write.
- **Address range:** addresses ≥ `DEPTH` are illegal. Writes to them are dropped; reads from them return X. The assertion exists only in simulation.

## Timing
- Clear duration is exactly `DEPTH` edges after the first edge with `reset`=0. `init_busy` is sampled 0 from edge `DEPTH` onward.
- Read latency is 1: `enb`/`addrb` sampled at edge N, then `dob` and `dob_vld`=1 valid after edge N. With `IRAM_OUTREG_EN`, latency is 2.
- Write to read of the same address on a later edge: the new data is visible when the read is issued ≥1 edge after the write.
- Back-to-back reads are supported every cycle. There is no backpressure.

## Configuration
- `IRAM_OUTREG_EN` defined:
  - An extra output register stage follows the RAM/bypass merge.
  - `dob` and `dob_vld` are delayed by one further cycle (latency 2).
  - The stage is reset to 0 and cleared by reset like the first stage.
  - The stage updates only when the first stage produced valid data, so `dob` holds otherwise.
- `IRAM_OUTREG_EN` undefined: a single register, latency 1.

## Test plan
- **Clear:** `DEPTH`=64, `INIT_VAL`=0xA5 repeated, pulse reset 1 cycle.
  - `init_busy` stays high for exactly 64 edges.
  - Reads of addresses 0, 31 and 63 then return the `INIT_VAL` pattern with `dob_vld` one cycle later (two with `IRAM_OUTREG_EN`).
- **Masked write:**
  - Write all-ones to address 5, then write 0 with `wea`=0x0001.
  - Reading address 5 returns all-ones except lane 0 = 0x00.
- **Read during write:** address 9 holds 0x11…, write 0x22… with all lanes while reading 9 on the same edge.
  - `RDW_NEW`=0 gives `dob`=0x11….
  - `RDW_NEW`=1 gives 0x22….
  - Repeat with a half-lane mask and expect merged data for `RDW_NEW`=1.
- **Reset mid-clear:** assert reset at counter 20, with a prior write attempted during busy.
  - The clear restarts and `init_busy` lasts `DEPTH` more edges.
  - The attempted write leaves no trace.
- **Streaming:** with `enb` held high for 64 cycles over addresses 0..63 after a pattern fill, `dob` follows address+1 at latency 1/2 with `dob_vld` continuous.
- **Hold:** with `enb` low for 10 cycles after a read, `dob` stays unchanged and `dob_vld`=0.
